// File: rtl/rv_biu.sv
// Multi-channel bus interface unit: arbitrates NCH requesters onto one external
// memory bus, one transfer outstanding, with ack timeout and interrupt capture.
module rv_biu #(
  parameter int NCH       = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int IFETCH_CH = 0,
  parameter int ARB_MODE  = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCH-1:0]            req_valid,
  output logic [NCH-1:0]            req_ready,
  input  logic [NCH-1:0]            req_wr,
  input  logic [NCH*ADDR_W-1:0]     req_addr,
  input  logic [NCH*(DATA_W/8)-1:0] req_be,
  input  logic [NCH*DATA_W-1:0]     req_wdata,
  output logic [NCH-1:0]            rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         pc,
  output logic                      ads,
  output logic                      rd_wr_n,
  output logic                      i_dn,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W/8-1:0]       be,
  output logic [DATA_W-1:0]         wr_data,
  input  logic [DATA_W-1:0]         rd_data,
  input  logic                      ack,
  input  logic                      intr,
  output logic                      irq_pending,
  input  logic                      irq_clr,
  output logic [1:0]                dbg_state
);
  localparam int BW = DATA_W / 8;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t              state_q;
  logic [CW-1:0]       ptr_q, g_q, gnt_idx;
  logic                gnt_any;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                tmo;
  logic [NCH-1:0]      rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q, wr_data_q;
  logic                rsp_err_q, ads_q, rd_wr_n_q, i_dn_q;
  logic [ADDR_W-1:0]   pc_q, addr_q;
  logic [BW-1:0]       be_q;
  logic                intr_q, intr_qq, irq_q;

  // Handshake: a request on channel k transfers on the rising edge where
  // req_valid[k] && req_ready[k]; req_ready is one-hot and only ever high in IDLE.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (ARB_MODE == 0) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = CW'(i);
        end
      end
    end else begin
      // Descending scan so the first channel after the pointer wins.
      for (int i = NCH; i >= 1; i--) begin
        if (req_valid[(int'(ptr_q) + i) % NCH]) begin
          gnt_any = 1'b1;
          gnt_idx = CW'((int'(ptr_q) + i) % NCH);
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE && gnt_any) ? (NCH'(1) << gnt_idx) : '0;
  assign cnt_d     = cnt_q + TW'(1);
  assign tmo       = (TIMEOUT != 0) && (cnt_d == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= CW'(NCH - 1);
      g_q         <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      pc_q        <= '0;
      ads_q       <= 1'b0;
      rd_wr_n_q   <= 1'b1;
      i_dn_q      <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wr_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            g_q       <= gnt_idx;
            ptr_q     <= gnt_idx;
            addr_q    <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            be_q      <= req_be[int'(gnt_idx)*BW +: BW];
            wr_data_q <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
            rd_wr_n_q <= ~req_wr[gnt_idx];
            i_dn_q    <= (int'(gnt_idx) == IFETCH_CH);
            ads_q     <= 1'b1;
            if (int'(gnt_idx) == IFETCH_CH)
              pc_q <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            state_q   <= ADDR;
          end
        end
        ADDR: begin
          ads_q   <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          // ack has priority over a timeout landing in the same cycle.
          if (ack) begin
            rsp_rdata_q <= rd_wr_n_q ? rd_data : '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= NCH'(1) << g_q;
            state_q     <= RESP;
          end else if (tmo) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NCH'(1) << g_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          cnt_q       <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Interrupt flag: rising edge of the registered intr sets, irq_clr clears, set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      intr_q  <= 1'b0;
      intr_qq <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      intr_q  <= intr;
      intr_qq <= intr_q;
      if (intr_q && !intr_qq) irq_q <= 1'b1;
      else if (irq_clr)       irq_q <= 1'b0;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign pc          = pc_q;
  assign ads         = ads_q;
  assign rd_wr_n     = rd_wr_n_q;
  assign i_dn        = i_dn_q;
  assign addr        = addr_q;
  assign be          = be_q;
  assign wr_data     = wr_data_q;
  assign irq_pending = irq_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_rv_biu.sv
// Bench for rv_biu: a round-robin instance and a fixed-priority instance share
// all stimulus; responses are scored against an expected queue.
module tb_rv_biu;
  localparam int NCH = 2, AW = 32, DW = 32, BW = 4, SW = 1 + NCH + DW;
  localparam logic [140:0] RST_VEC = {2'b0, 2'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1,
                                      1'b0, 32'h0, 4'h0, 32'h0, 1'b0};

  logic clk = 1'b0;
  logic reset, ack, intr, irq_clr;
  logic [NCH-1:0] req_valid, req_wr;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*BW-1:0] req_be;
  logic [NCH*DW-1:0] req_wdata;
  logic [DW-1:0] rd_data;

  logic [NCH-1:0] req_ready, rsp_valid, req_ready_f, rsp_valid_f;
  logic [DW-1:0] rsp_rdata, wr_data, rsp_rdata_f, wr_data_f;
  logic [AW-1:0] pc, addr, pc_f, addr_f;
  logic [BW-1:0] be, be_f;
  logic rsp_err, ads, rd_wr_n, i_dn, irq_pending;
  logic rsp_err_f, ads_f, rd_wr_n_f, i_dn_f, irq_pending_f;
  logic [1:0] dbg_state, dbg_state_f;

  logic [SW-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [NCH-1:0] gnt, gnt_f, ready_addr, rsp_f, after;
    logic ads_a, ads_w, rwn, idn;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    int cyc;
    logic [SW-1:0] rsp;
    logic [1:0] st_after;
  } xfer_obs_t;

  always #5 clk = ~clk;

  rv_biu #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .IFETCH_CH(0), .ARB_MODE(1), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .pc(pc), .ads(ads), .rd_wr_n(rd_wr_n),
    .i_dn(i_dn), .addr(addr), .be(be), .wr_data(wr_data), .rd_data(rd_data), .ack(ack),
    .intr(intr), .irq_pending(irq_pending), .irq_clr(irq_clr), .dbg_state(dbg_state));

  rv_biu #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .IFETCH_CH(0), .ARB_MODE(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_f), .req_wr(req_wr),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .rsp_valid(rsp_valid_f),
    .rsp_rdata(rsp_rdata_f), .rsp_err(rsp_err_f), .pc(pc_f), .ads(ads_f), .rd_wr_n(rd_wr_n_f),
    .i_dn(i_dn_f), .addr(addr_f), .be(be_f), .wr_data(wr_data_f), .rd_data(rd_data), .ack(ack),
    .intr(intr), .irq_pending(irq_pending_f), .irq_clr(irq_clr), .dbg_state(dbg_state_f));

  function automatic logic [140:0] out_vec(input bit fp);
    if (fp) return {req_ready_f, rsp_valid_f, rsp_rdata_f, rsp_err_f, pc_f, ads_f, rd_wr_n_f,
                    i_dn_f, addr_f, be_f, wr_data_f, irq_pending_f};
    return {req_ready, rsp_valid, rsp_rdata, rsp_err, pc, ads, rd_wr_n, i_dn, addr, be,
            wr_data, irq_pending};
  endfunction

  // Driver: called just after a negedge with requests set up; runs one transfer
  // and records what the bus and response ports showed along the way.
  task automatic drive_xfer(input int ack_wait, input logic [DW-1:0] rd, input bit no_ack,
                            input bit drop, output xfer_obs_t o);
    bit seen = 0;
    #1;
    o.gnt = req_ready;
    o.gnt_f = req_ready_f;
    @(negedge clk);
    if (drop) req_valid = '0;
    o.ads_a = ads; o.rwn = rd_wr_n; o.idn = i_dn; o.addr = addr; o.be = be; o.wd = wr_data;
    o.ready_addr = req_ready;
    @(negedge clk);
    o.ads_w = ads;
    o.cyc = 0;
    while (!seen && o.cyc < 20) begin
      if (!no_ack && o.cyc == ack_wait) begin ack = 1'b1; rd_data = rd; end
      @(negedge clk);
      ack = 1'b0;
      rd_data = $urandom;
      o.cyc++;
      if (rsp_valid != '0) seen = 1;
    end
    o.rsp = {rsp_err, rsp_valid, rsp_rdata};
    o.rsp_f = rsp_valid_f;
    @(negedge clk);
    o.after = rsp_valid;
    o.st_after = dbg_state;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0; req_be = '0; req_wdata = '0;
    rd_data = '0; ack = 1'b0; intr = 1'b0; irq_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_vec(0) !== RST_VEC) begin tests_failed++; $display("FAIL reset_outputs: got %h expected %h", out_vec(0), RST_VEC); end
    tests_run++;
    if (out_vec(1) !== RST_VEC) begin tests_failed++; $display("FAIL reset_outputs_fp: got %h expected %h", out_vec(1), RST_VEC); end
    tests_run++;
    if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_single_read();
    xfer_obs_t o;
    logic [SW-1:0] e;
    req_valid = 2'b01; req_wr = 2'b00; req_addr[0 +: AW] = 32'h0000_1000; req_be[0 +: BW] = 4'hF;
    exp_q.push_back({1'b0, 2'b01, 32'hDEAD_BEEF});
    drive_xfer(1, 32'hDEAD_BEEF, 0, 1, o);
    e = exp_q.pop_front();
    tests_run++;
    if (o.gnt !== 2'b01 || o.gnt_f !== 2'b01) begin tests_failed++; $display("FAIL read_grant: got %b/%b expected 01/01", o.gnt, o.gnt_f); end
    tests_run++;
    if ({o.ads_a, o.rwn, o.idn, o.addr, o.ready_addr} !== {3'b111, 32'h0000_1000, 2'b00}) begin
      tests_failed++; $display("FAIL read_bus: got ads=%b rwn=%b idn=%b addr=%h rdy=%b expected 1 1 1 00001000 00", o.ads_a, o.rwn, o.idn, o.addr, o.ready_addr);
    end
    tests_run++;
    if (o.ads_w !== 1'b0 || o.cyc !== 2) begin tests_failed++; $display("FAIL read_timing: got ads_wait=%b cycles=%0d expected 0 2", o.ads_w, o.cyc); end
    tests_run++;
    if (o.rsp !== e) begin tests_failed++; $display("FAIL read_rsp: got %h expected %h", o.rsp, e); end
    tests_run++;
    if (o.after !== 2'b00 || o.st_after !== 2'd0) begin tests_failed++; $display("FAIL read_rsp_pulse: got %b st=%0d expected 00 st=0", o.after, o.st_after); end
    tests_run++;
    if (pc !== 32'h0000_1000) begin tests_failed++; $display("FAIL read_pc: got %h expected 00001000", pc); end
  endtask

  task automatic test_write();
    xfer_obs_t o;
    logic [SW-1:0] e;
    req_valid = 2'b10; req_wr = 2'b10; req_addr[AW +: AW] = 32'h0000_2004;
    req_be[BW +: BW] = 4'b0011; req_wdata[DW +: DW] = 32'h0000_A5A5;
    exp_q.push_back({1'b0, 2'b10, 32'h0});
    drive_xfer(0, 32'h1234_5678, 0, 1, o);
    e = exp_q.pop_front();
    tests_run++;
    if (o.gnt !== 2'b10) begin tests_failed++; $display("FAIL write_grant: got %b expected 10", o.gnt); end
    tests_run++;
    if ({o.ads_a, o.rwn, o.idn, o.addr, o.be, o.wd} !== {3'b100, 32'h0000_2004, 4'b0011, 32'h0000_A5A5}) begin
      tests_failed++; $display("FAIL write_bus: got ads=%b rwn=%b idn=%b addr=%h be=%b wd=%h", o.ads_a, o.rwn, o.idn, o.addr, o.be, o.wd);
    end
    tests_run++;
    if (o.cyc !== 1 || o.rsp !== e) begin tests_failed++; $display("FAIL write_rsp: got cyc=%0d rsp=%h expected 1 %h", o.cyc, o.rsp, e); end
    tests_run++;
    if (pc !== 32'h0000_1000) begin tests_failed++; $display("FAIL write_pc_hold: got %h expected 00001000", pc); end
  endtask

  task automatic test_contention();
    xfer_obs_t o;
    logic [SW-1:0] e;
    logic [NCH-1:0] g;
    logic [DW-1:0] rd;
    req_wr = 2'b00; req_addr[0 +: AW] = 32'h100; req_addr[AW +: AW] = 32'h200; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
      rd = 32'h1000_0000 + 32'(k);
      exp_q.push_back({1'b0, g, rd});
      drive_xfer(0, rd, 0, (k == 3), o);
      e = exp_q.pop_front();
      tests_run++;
      if (o.gnt !== g || o.gnt_f !== 2'b01) begin tests_failed++; $display("FAIL contention_grant[%0d]: got rr=%b fp=%b expected rr=%b fp=01", k, o.gnt, o.gnt_f, g); end
      tests_run++;
      if (o.addr !== ((k % 2 == 0) ? 32'h100 : 32'h200)) begin tests_failed++; $display("FAIL contention_addr[%0d]: got %h", k, o.addr); end
      tests_run++;
      if (o.rsp !== e || o.rsp_f !== 2'b01) begin tests_failed++; $display("FAIL contention_rsp[%0d]: got %h fp=%b expected %h fp=01", k, o.rsp, o.rsp_f, e); end
    end
    tests_run++;
    if (pc !== 32'h100 || pc_f !== 32'h100) begin tests_failed++; $display("FAIL contention_pc: got %h/%h expected 00000100", pc, pc_f); end
  endtask

  task automatic test_timeout();
    xfer_obs_t o;
    logic [SW-1:0] e;
    req_valid = 2'b10; req_wr = 2'b00; req_addr[AW +: AW] = 32'h3000;
    exp_q.push_back({1'b1, 2'b10, 32'h0});
    drive_xfer(0, 32'h0, 1, 1, o);
    e = exp_q.pop_front();
    tests_run++;
    if (o.cyc !== 4) begin tests_failed++; $display("FAIL timeout_cycles: got %0d expected 4", o.cyc); end
    tests_run++;
    if (o.rsp !== e) begin tests_failed++; $display("FAIL timeout_rsp: got %h expected %h", o.rsp, e); end
    req_valid = 2'b01; req_addr[0 +: AW] = 32'h4000;
    exp_q.push_back({1'b0, 2'b01, 32'hCAFE_F00D});
    drive_xfer(2, 32'hCAFE_F00D, 0, 1, o);
    e = exp_q.pop_front();
    tests_run++;
    if (o.cyc !== 3 || o.rsp !== e) begin tests_failed++; $display("FAIL after_timeout_rsp: got cyc=%0d rsp=%h expected 3 %h", o.cyc, o.rsp, e); end
  endtask

  task automatic test_reset_in_wait();
    xfer_obs_t o;
    logic [SW-1:0] e;
    int spurious = 0;
    req_valid = 2'b01; req_wr = 2'b00; req_addr[0 +: AW] = 32'h5000;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (dbg_state !== 2'd2) begin tests_failed++; $display("FAIL rst_wait_state: got %0d expected 2", dbg_state); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (out_vec(0) !== RST_VEC || out_vec(1) !== RST_VEC) begin
      tests_failed++; $display("FAIL rst_wait_outputs: got %h expected %h", out_vec(0), RST_VEC);
    end
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1; rd_data = $urandom;
      @(negedge clk);
      if (rsp_valid != '0 || rsp_valid_f != '0) spurious++;
    end
    ack = 1'b0;
    tests_run++;
    if (spurious !== 0) begin tests_failed++; $display("FAIL rst_wait_no_rsp: got %0d pulses expected 0", spurious); end
    req_valid = 2'b11; req_addr[0 +: AW] = 32'h6000; req_addr[AW +: AW] = 32'h7000;
    exp_q.push_back({1'b0, 2'b01, 32'h0BAD_F00D});
    drive_xfer(0, 32'h0BAD_F00D, 0, 1, o);
    e = exp_q.pop_front();
    tests_run++;
    if (o.gnt !== 2'b01 || o.rsp !== e) begin tests_failed++; $display("FAIL rst_wait_regrant: got gnt=%b rsp=%h expected 01 %h", o.gnt, o.rsp, e); end
  endtask

  task automatic test_irq();
    intr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    tests_run++;
    if (irq_pending !== 1'b1 || irq_pending_f !== 1'b1) begin tests_failed++; $display("FAIL irq_set_wins: got %b expected 1", irq_pending); end
    repeat (2) @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    tests_run++;
    if (irq_pending !== 1'b0) begin tests_failed++; $display("FAIL irq_clear: got %b expected 0", irq_pending); end
    repeat (5) @(negedge clk);
    tests_run++;
    if (irq_pending !== 1'b0) begin tests_failed++; $display("FAIL irq_level_no_reset: got %b expected 0", irq_pending); end
    intr = 1'b0;
    repeat (3) @(negedge clk);
    intr = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (irq_pending !== 1'b1) begin tests_failed++; $display("FAIL irq_second_edge: got %b expected 1", irq_pending); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_timeout();
    test_reset_in_wait();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rv_biu.md
Name: rv_biu

Overview:
Parametrised multi-channel bus interface unit, the successor to the single-requester bus unit in the CPU top level.
- Arbitrates NCH requester channels onto the single external memory bus: ads, rd_wr_n, i_dn, addr, be, wr_data, rd_data, ack.
- Channel IFETCH_CH is the instruction-fetch port; all other channels are data (load/store) ports.
- Adds round-robin or fixed-priority arbitration, an ack timeout with error response, and edge-latched interrupt capture.

Parameters:
NCH, 2, number of requester channels (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width; must be a multiple of 8
IFETCH_CH, 0, channel index whose transfers drive i_dn=1
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT, 255, max cycles waiting for ack before error; 0 disables timeout

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  NCH  per-channel request valid
req_ready  out  NCH  per-channel accept strobe; at most one bit set (one-hot)
req_wr  in  NCH  per-channel 1 = write, 0 = read
req_addr  in  NCH*ADDR_W  per-channel address, channel k at [k*ADDR_W +: ADDR_W]
req_be  in  NCH*(DATA_W/8)  per-channel byte enables
req_wdata  in  NCH*DATA_W  per-channel write data
rsp_valid  out  NCH  one-cycle completion pulse on the owning channel
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  1 = transfer timed out, valid with rsp_valid
pc  out  ADDR_W  address of the most recently accepted IFETCH_CH request
ads  out  1  address strobe, one-cycle pulse per transfer
rd_wr_n  out  1  1 = read, 0 = write
i_dn  out  1  1 = instruction transfer, 0 = data transfer
addr  out  ADDR_W  bus address
be  out  DATA_W/8  bus byte enables
wr_data  out  DATA_W  bus write data
rd_data  in  DATA_W  bus read data, sampled when ack=1
ack  in  1  bus completion
intr  in  1  interrupt request level
irq_pending  out  1  latched interrupt flag
irq_clr  in  1  clears irq_pending

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, pc=0, ads=0, rd_wr_n=1, i_dn=0, addr=0, be=0, wr_data=0, irq_pending=0.
- Reset also forces state IDLE, sets the round-robin pointer to NCH-1 (so channel 0 has first priority), and clears the timeout counter.
- Reset mid-transfer abandons the transfer; no rsp_valid is issued for it.

FSM states: IDLE, ADDR, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant one channel g and assert req_ready[g] combinationally in the same cycle.
  - The request is accepted on that edge: latch wr, addr, be, wdata and g.
  - Go to ADDR. req_ready is never asserted outside IDLE.
- ADDR:
  - ads=1 for exactly one cycle.
  - addr, be, rd_wr_n=~wr, i_dn=(g==IFETCH_CH) and wr_data are registered.
  - Go to WAIT. ack is ignored in this cycle.
- WAIT:
  - Bus outputs are held stable; ads=0.
  - On ack=1: capture rd_data (0 for writes), set rsp_err=0, go to RESP.
  - Otherwise increment the counter. If TIMEOUT != 0 and the counter reaches TIMEOUT: rsp_rdata=0, rsp_err=1, go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP:
  - rsp_valid[g]=1 for one cycle; clear the counter; go to IDLE.
  - rsp_rdata and rsp_err hold their values until the next response.
- Minimum latency: accept at cycle 0, ads at 1, ack at 2, rsp_valid at 3. One transfer is outstanding at a time.
- Acks in IDLE, ADDR or RESP are ignored.

Arbitration:
- ARB_MODE=0: lowest set index wins.
- ARB_MODE=1: search starts at pointer+1 modulo NCH. The pointer updates to g on grant.
- A single requester always wins immediately.

Other outputs and flags:
- pc updates on acceptance of an IFETCH_CH request only.
- irq_pending sets on a 0->1 edge of registered intr, clears on irq_clr. If set and clear occur in the same cycle, set wins.

Test Plan:
- Single read: ch0 read addr=0x0000_1000, ack 2 cycles after ads with rd_data=0xDEAD_BEEF -> ads pulse with i_dn=1, rd_wr_n=1; rsp_valid[0] then rsp_rdata=0xDEAD_BEEF, rsp_err=0; pc=0x1000.
- Write: ch1 write addr=0x2004, be=4'b0011, wdata=0x0000_A5A5 -> ads with rd_wr_n=0, i_dn=0, be=0011, wr_data=0xA5A5; rsp_valid[1] one cycle after ack.
- Contention: ch0 and ch1 both held valid for 4 transfers -> ARB_MODE=1 grants 0,1,0,1; ARB_MODE=0 grants 0,0,0,0.
- Timeout: TIMEOUT=4, ack never asserted -> rsp_valid after 4 WAIT cycles with rsp_err=1, rsp_rdata=0. Next request proceeds normally.
- Reset in WAIT: assert reset for 1 cycle -> all outputs at reset values, no rsp_valid. Next request is granted to ch0 first.
- Interrupt: intr rises, and irq_clr is pulsed in the same cycle that irq_pending would set -> irq_pending=1. Later irq_clr alone -> irq_pending=0. intr held high does not re-set the flag.
